rip_regfile_mp: RTL and testbench
=================================

// Module: rip_regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file for the next rip pipeline.
//   Has NUM_WR write ports, NUM_RD registered read ports with same-cycle write
//   bypass, and a per-register busy scoreboard for in-flight producers.
//   It has a read-hold (stall) mode that keeps each read port's address and
//   keeps refreshing its data from writeback.
//   It sits between decode/issue (reads, busy marking) and writeback.
// PARAMETERS
//   XLEN     32      data width per register
//   NREGS    32      number of architectural registers; index 0 reads as zero
//   NUM_RD   2       number of read ports
//   NUM_WR   1       number of write ports
//   SP_IDX   2       index of the stack-pointer register
//   SP_INIT  SP_ADDR reset value of register SP_IDX (from rip_common)
//   AW       $clog2(NREGS)  register-index width (derived, not overridable)
// PORTS
//   clk       in   1            clock; all state updates on posedge
//   rst_n     in   1            synchronous reset, active-low
//   wen       in   NUM_WR       per-port write enable
//   wr_num    in   NUM_WR*AW    per-port destination index (port p at [p*AW +: AW])
//   wdata     in   NUM_WR*XLEN  per-port write data
//   mark_en   in   1            set the busy bit of mark_num (instruction issued)
//   mark_num  in   AW           destination index to mark busy
//   rd_hold   in   1            stall: re-read the latched indices, ignore rd_num
//   rd_num    in   NUM_RD*AW    per-port source index
//   rdata     out  NUM_RD*XLEN  registered read data
//   rbusy     out  NUM_RD       registered busy flag of the read register
// BEHAVIOUR
//   Reset: synchronous (rst_n low at posedge), not gated by rd_hold.
//   - Reg[SP_IDX] <= SP_INIT. All other registers <= 0.
//   - busy <= 0. rdata <= 0. rbusy <= 0. Latched read indices <= 0.
//   - Reset mid-operation discards all pending writes and marks in that cycle.
//   Write:
//   - Each posedge, for every port p with wen[p]=1 and wr_num!=0: reg[wr_num] <= wdata.
//   - Writes to index 0 are dropped.
//   - Several ports on the same index: the highest p wins.
//   Busy scoreboard:
//   - An accepted write (wen[p]=1, index!=0) clears busy[index].
//   - mark_en=1 with mark_num!=0 sets busy[mark_num].
//   - Set and clear on the same index in the same cycle: set wins (newer producer).
//   - busy[0] is always 0.
//   Read (latency 1):
//   - eff[r] = rd_hold ? lat[r] : rd_num[r]; lat[r] <= eff[r] every cycle.
//   - rdata[r] <= eff==0 ? 0 : (matching write this cycle ? its wdata, highest p : reg[eff]).
//   - rbusy[r] <= busy value of eff after this cycle's set/clear (eff==0 -> 0).
//   - While rd_hold=1, rdata/rbusy keep tracking writeback to the held indices.
//     This prevents stale operands on stall release.
//   - No read-enable: outputs update every non-reset cycle.
//   - Index >= NREGS (non-power-of-2 NREGS): write dropped, read returns 0, busy 0.
// TESTING
//   1 Reset: rst_n=0 one cycle, read x2,x5 -> rdata=SP_INIT,0; rbusy=0,0.
//   2 Bypass: wen=1 x5<=0xDEADBEEF and rd_num x5 in same cycle
//     -> next cycle rdata=0xDEADBEEF.
//   3 x0: write x0<=0x1234, then read x0 -> rdata=0.
//   4 Write-port priority (NUM_WR=2): both ports write x7, p0=0x11, p1=0x22
//     -> reg x7=0x22; bypass also gives 0x22.
//   5 Scoreboard: mark x9 -> next read rbusy=1.
//     Write x9 with mark x9 in the same cycle -> busy stays 1.
//     Write x9 alone -> rbusy=0, rdata=new value.
//   6 Hold: rd_num=x3, then rd_hold=1 with rd_num=x4 while x3<=0x55
//     -> rdata=0x55 (x3 tracked, not x4).
//     Assert rst_n=0 mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rip_regfile_mp.sv
// rip_regfile_mp: multi-port register file with write bypass, busy scoreboard and read-hold
module rip_regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int SP_IDX = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_8000,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_WR-1:0]      wen,
    input  logic [NUM_WR*AW-1:0]   wr_num,
    input  logic [NUM_WR*XLEN-1:0] wdata,
    input  logic                   mark_en,
    input  logic [AW-1:0]          mark_num,
    input  logic                   rd_hold,
    input  logic [NUM_RD*AW-1:0]   rd_num,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy
);
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] regs_nx [NREGS];
    logic [NREGS-1:0] busy, busy_nx;
    logic [AW-1:0] lat [NUM_RD];
    logic [AW-1:0] eff [NUM_RD];
    logic [NUM_RD*XLEN-1:0] rdata_nx;
    logic [NUM_RD-1:0] rbusy_nx;

    function automatic logic ok(input logic [AW-1:0] i);
        return i != '0 && 32'(i) < NREGS;
    endfunction

    always_comb begin
        regs_nx = regs;
        busy_nx = busy;
        rdata_nx = '0;
        rbusy_nx = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wen[p] && ok(wr_num[p*AW +: AW])) begin
                regs_nx[wr_num[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
                busy_nx[wr_num[p*AW +: AW]] = 1'b0;
            end
        end
        if (mark_en && ok(mark_num)) busy_nx[mark_num] = 1'b1;
        for (int r = 0; r < NUM_RD; r++) begin
            eff[r] = rd_hold ? lat[r] : rd_num[r*AW +: AW];
            rdata_nx[r*XLEN +: XLEN] = ok(eff[r]) ? regs_nx[eff[r]] : '0;
            rbusy_nx[r] = ok(eff[r]) ? busy_nx[eff[r]] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            for (int r = 0; r < NUM_RD; r++) lat[r] <= '0;
            busy <= '0;
            rdata <= '0;
            rbusy <= '0;
        end else begin
            regs <= regs_nx;
            lat <= eff;
            busy <= busy_nx;
            rdata <= rdata_nx;
            rbusy <= rbusy_nx;
        end
    end
endmodule

// File: tb/tb_rip_regfile_mp.sv
// tb_rip_regfile_mp: scoreboard bench for rip_regfile_mp (2 write ports, 2 read ports)
module tb_rip_regfile_mp;
    localparam logic [31:0] SP = 32'h0001_FFF0;
    logic clk = 0, rst_n = 0, mark_en = 0, rd_hold = 0;
    logic [1:0] wen = 0;
    logic [9:0] wr_num = 0, rd_num = 0;
    logic [63:0] wdata = 0, rdata;
    logic [4:0] mark_num = 0;
    logic [1:0] rbusy;
    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] d0, d1;
        logic [1:0] b;
    } exp_t;
    exp_t q[$];

    logic [31:0] mreg [32];
    logic [31:0] mbusy;
    logic [4:0] mlat [2];

    rip_regfile_mp #(.NUM_WR(2), .NUM_RD(2), .SP_INIT(SP)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wr_num(wr_num), .wdata(wdata),
        .mark_en(mark_en), .mark_num(mark_num), .rd_hold(rd_hold), .rd_num(rd_num),
        .rdata(rdata), .rbusy(rbusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input bit rs, input bit [1:0] we,
                        input bit [4:0] a0, input bit [31:0] d0,
                        input bit [4:0] a1, input bit [31:0] d1,
                        input bit me, input bit [4:0] mn, input bit hd,
                        input bit [4:0] r0, input bit [4:0] r1);
        exp_t e, g;
        logic [4:0] ef [2];
        @(negedge clk);
        rst_n = rs; wen = we; wr_num = {a1, a0}; wdata = {d1, d0};
        mark_en = me; mark_num = mn; rd_hold = hd; rd_num = {r1, r0};
        if (!rs) begin
            for (int i = 0; i < 32; i++) mreg[i] = (i == 2) ? SP : 32'h0;
            mbusy = 0; mlat[0] = 0; mlat[1] = 0;
            e.d0 = 0; e.d1 = 0; e.b = 0;
        end else begin
            if (we[0] && a0 != 0) begin mreg[a0] = d0; mbusy[a0] = 0; end
            if (we[1] && a1 != 0) begin mreg[a1] = d1; mbusy[a1] = 0; end
            if (me && mn != 0) mbusy[mn] = 1;
            ef[0] = hd ? mlat[0] : r0;
            ef[1] = hd ? mlat[1] : r1;
            e.d0 = ef[0] == 0 ? 32'h0 : mreg[ef[0]];
            e.d1 = ef[1] == 0 ? 32'h0 : mreg[ef[1]];
            e.b = {ef[1] != 0 && mbusy[ef[1]], ef[0] != 0 && mbusy[ef[0]]};
            mlat = ef;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk({tag, ".d0"}, rdata[31:0], g.d0);
        chk({tag, ".d1"}, rdata[63:32], g.d1);
        chk({tag, ".b"}, {30'h0, rbusy}, {30'h0, g.b});
    endtask

    initial begin
        step("rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5);
        step("rd_sp",   1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5);
        chk("sp_const", rdata[31:0], SP);
        step("bypass",  1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 2);
        chk("bypass_const", rdata[31:0], 32'hDEADBEEF);
        step("wr_x0",   1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 5);
        step("rd_x0",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_const", rdata[31:0], 32'h0);
        step("prio_byp", 1, 3, 7, 32'h11, 7, 32'h22, 0, 0, 0, 7, 7);
        chk("prio_const", rdata[63:32], 32'h22);
        step("prio_rd", 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        step("mark9",   1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        step("busy9",   1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        chk("busy_const", {30'h0, rbusy}, 32'h3);
        step("wr_mark9", 1, 1, 9, 32'h99, 0, 0, 1, 9, 0, 9, 0);
        step("still9",  1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        step("wr9",     1, 2, 0, 0, 9, 32'h9A, 0, 0, 0, 9, 0);
        chk("clr_const", {31'h0, rbusy[0]}, 32'h0);
        step("mark0",   1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("set_x4",  1, 1, 4, 32'h44, 0, 0, 0, 0, 0, 3, 4);
        step("hold",    1, 1, 3, 32'h55, 0, 0, 0, 0, 1, 4, 9);
        chk("hold_const", rdata[31:0], 32'h55);
        step("hold2",   1, 2, 0, 0, 9, 32'h77, 0, 0, 1, 4, 3);
        step("hold_rst", 0, 1, 3, 32'h66, 0, 0, 1, 3, 1, 4, 4);
        chk("rst_const", rdata[31:0], 32'h0);
        step("post_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 2);
        step("rd_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        for (int i = 0; i < 300; i++)
            step("rnd", $urandom_range(39) != 0, 2'($urandom),
                 5'($urandom_range(7)), $urandom, 5'($urandom_range(7)), $urandom,
                 $urandom_range(2) == 0, 5'($urandom_range(7)), $urandom_range(3) == 0,
                 5'($urandom_range(7)), 5'($urandom_range(31)));
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
